axis_tlast_framer: RTL

- Parametrised successor to the fixed-length AXI-Stream TLAST generator.
- Sits between a free-running sample source (ADC/DMA datapath) and a packet-oriented consumer (DMA S2MM, framer).
- Adds runtime packet length, optional packet-count limit, graceful stop, and full AXIS backpressure through a 2-entry skid buffer.
- Inserts TLAST on the last beat of every packet.

---
 rtl/axis_tlast_framer_if.sv | 13 +
 rtl/axis_tlast_framer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/axis_tlast_framer_if.sv
// AXI-Stream beat bundle shared by the framer's input and output sides.
interface axis_tlast_framer_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    // The framer generates its own TLAST, so the upstream side carries none.
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_tlast_framer.sv
// AXI-Stream TLAST framer: cuts a free-running sample stream into packets of a
// runtime length, with an optional packet-count limit, graceful stop and a
// 2-entry skid buffer so that input ready is registered.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | input held off, waiting for a start with a non-zero length
// RUN   | accepting beats, tagging every len-th one as last
// DRAIN | stop requested mid-packet; finish the current packet
// FLUSH | input held off, emptying the skid buffer before IDLE
module axis_tlast_framer #(
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   axis_aclk,
    input  logic                   axis_areset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [LEN_WIDTH-1:0]   i_pkt_len,
    input  logic [CNT_WIDTH-1:0]   i_num_pkts,
    axis_tlast_framer_if.slave     s_axis,
    axis_tlast_framer_if.master    m_axis,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [CNT_WIDTH-1:0]   o_pkt_count,
    output logic                   o_len_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_m1, beat_q, beat_d;
    logic [CNT_WIDTH-1:0]   num_q, pkt_q, pkt_d, pkt_inc;
    logic                   len_err_q, done_arm_q, done_arm_d;
    logic                   start_ok, len_err_set;

    logic [DATA_WIDTH-1:0]  buf_data [2];
    logic [1:0]             buf_last;
    logic                   rd_ptr, wr_ptr;
    logic [1:0]             fill_q, fill_d;
    logic                   s_ready_q, s_ready_d;
    logic                   m_valid, in_hs, out_hs, beat_last, pkts_complete;

    assign len_m1    = len_q - LEN_WIDTH'(1);
    assign beat_last = (beat_q == len_m1);
    assign pkt_inc   = pkt_q + CNT_WIDTH'(1);
    assign m_valid   = (fill_q != 2'd0);
    assign in_hs     = s_axis.tvalid & s_ready_q;
    assign out_hs    = m_valid & m_axis.tready;
    assign fill_d    = fill_q + {1'b0, in_hs} - {1'b0, out_hs};

    assign pkts_complete = in_hs & beat_last & (num_q != '0) & (pkt_inc == num_q);

    // Next-state, beat/packet counter and done-arm decisions.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        pkt_d       = pkt_q;
        done_arm_d  = done_arm_q;
        start_ok    = 1'b0;
        len_err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_pkt_len != '0) begin
                        start_ok   = 1'b1;
                        state_d    = RUN;
                        beat_d     = '0;
                        pkt_d      = '0;
                        done_arm_d = 1'b0;
                    end else begin
                        len_err_set = 1'b1;
                    end
                end
            end
            RUN, DRAIN: begin
                if (in_hs) begin
                    if (beat_last) begin
                        beat_d = '0;
                        pkt_d  = pkt_inc;
                    end else begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end
                end
                if (pkts_complete) begin
                    state_d    = FLUSH;
                    done_arm_d = 1'b1;
                end else if (state_q == DRAIN) begin
                    if (in_hs && beat_last) state_d = FLUSH;
                end else if (i_stop) begin
                    // Judge the boundary after this cycle's beat, so a stop that
                    // coincides with a packet's first beat still drains the packet.
                    state_d = (beat_d == '0) ? FLUSH : DRAIN;
                end
            end
            FLUSH: begin
                if (fill_q == 2'd0) begin
                    state_d    = IDLE;
                    done_arm_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is registered from the predicted fill so it never follows m_axis.tready combinationally.
    always_comb begin
        s_ready_d = ((state_d == RUN) || (state_d == DRAIN)) && (fill_d != 2'd2);
    end

    // Control state, counters and latched configuration.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            pkt_q      <= '0;
            len_q      <= '0;
            num_q      <= '0;
            len_err_q  <= 1'b0;
            done_arm_q <= 1'b0;
            s_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            pkt_q      <= pkt_d;
            done_arm_q <= done_arm_d;
            s_ready_q  <= s_ready_d;
            if (start_ok) begin
                len_q     <= i_pkt_len;
                num_q     <= i_num_pkts;
                len_err_q <= 1'b0;
            end else if (len_err_set) begin
                len_err_q <= 1'b1;
            end
        end
    end

    // Two-entry skid buffer holding {tdata, tlast}; the head entry stays put until popped.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            for (int i = 0; i < 2; i++) buf_data[i] <= '0;
            buf_last <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fill_q   <= 2'd0;
        end else begin
            if (in_hs) begin
                buf_data[wr_ptr] <= s_axis.tdata;
                buf_last[wr_ptr] <= beat_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (out_hs) rd_ptr <= ~rd_ptr;
            fill_q <= fill_d;
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = buf_data[rd_ptr];
    assign m_axis.tlast  = buf_last[rd_ptr] & m_valid;

    assign o_busy      = (state_q != IDLE);
    // Only a count-limited run arms done; the final beat is the sole entry left in FLUSH.
    assign o_done      = (state_q == FLUSH) & done_arm_q & out_hs & (fill_q == 2'd1);
    assign o_pkt_count = pkt_q;
    assign o_len_err   = len_err_q;

endmodule
